// File: rtl/universal_counter.sv
// Modulo-N counter with run-time up/down/ping-pong/hold modes, wrap or
// saturate at the range limits, parallel load, terminal count and a wrap pulse.
module universal_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = MODULUS - 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             wrap
);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("universal_counter: MODULUS must lie in 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
    $error("universal_counter: RESET_VAL must lie in 0..MODULUS-1");
  end

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_clamped;
  logic             pp_up;
  logic [WIDTH-1:0] pp_next;

  // Out-of-range load values clamp to the top of the count range.
  assign load_clamped = (load_val > MAX) ? MAX : load_val;

  // Ping-pong: an end value always steps back inward, which also repairs a
  // direction that points out of range (e.g. after leaving saturated up mode).
  always_comb begin
    pp_up = dir_q;
    if (count_q == MAX)       pp_up = 1'b0;
    else if (count_q == ZERO) pp_up = 1'b1;
    pp_next = pp_up ? count_q + ONE : count_q - ONE;
  end

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = RST;
      dir_d   = 1'b1;
    end else if (load) begin
      count_d = load_clamped;
      if (mode == MODE_PP) begin
        if (load_clamped == ZERO)     dir_d = 1'b1;
        else if (load_clamped == MAX) dir_d = 1'b0;
      end
    end else if (en) begin
      case (mode)
        MODE_UP: begin
          dir_d = 1'b1;
          if (count_q != MAX) begin
            count_d = count_q + ONE;
          end else if (!sat) begin
            count_d = ZERO;
            wrap_d  = 1'b1;
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b0;
          if (count_q != ZERO) begin
            count_d = count_q - ONE;
          end else if (!sat) begin
            count_d = MAX;
            wrap_d  = 1'b1;
          end
        end
        MODE_PP: begin
          count_d = pp_next;
          if (pp_next == MAX)       dir_d = 1'b0;
          else if (pp_next == ZERO) dir_d = 1'b1;
          else                      dir_d = pp_up;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= RST;
      dir_q   <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    tc = 1'b0;
    if (en && !clear && !load) begin
      case (mode)
        MODE_UP:   tc = (count_q == MAX);
        MODE_DOWN: tc = (count_q == ZERO);
        MODE_PP:   tc = (dir_q && count_q == MAX) || (!dir_q && count_q == ZERO);
        default:   tc = 1'b0;
      endcase
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_universal_counter.sv
// Bench for universal_counter: three instances (MODULUS 10, 4, 16) share one
// stimulus stream; directed tables, hand sequences, then random vs a model.
module tb_universal_counter;

  typedef struct {
    bit       clr;
    bit       ld;
    bit       en;
    bit [1:0] mode;
    bit       sat;
    bit [3:0] lv;
  } in_t;

  typedef struct {
    in_t i;
    bit  tc;
    int  cnt;
    bit  dir;
    bit  wrap;
  } vec_t;

  logic       clk = 1'b0;
  logic       clear, en, load, sat;
  logic [3:0] load_val;
  logic [1:0] mode;

  logic [3:0] cnt_w [3];
  logic       dir_w [3];
  logic       tc_w  [3];
  logic       wrap_w[3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  universal_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(9)) u10 (
    .clk(clk), .clear(clear), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .sat(sat), .count(cnt_w[0]), .dir(dir_w[0]), .tc(tc_w[0]),
    .wrap(wrap_w[0]));

  universal_counter #(.WIDTH(4), .MODULUS(4)) u4 (
    .clk(clk), .clear(clear), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .sat(sat), .count(cnt_w[1]), .dir(dir_w[1]), .tc(tc_w[1]),
    .wrap(wrap_w[1]));

  universal_counter u16 (
    .clk(clk), .clear(clear), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .sat(sat), .count(cnt_w[2]), .dir(dir_w[2]), .tc(tc_w[2]),
    .wrap(wrap_w[2]));

  function automatic in_t I(bit c, bit l, bit e, bit [1:0] m, bit s, int lv);
    in_t x;
    x.clr = c; x.ld = l; x.en = e; x.mode = m; x.sat = s; x.lv = 4'(lv);
    return x;
  endfunction

  function automatic vec_t mk(in_t x, bit t, int c, bit d, bit w);
    vec_t v;
    v.i = x; v.tc = t; v.cnt = c; v.dir = d; v.wrap = w;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(in_t x);
    clear = x.clr; load = x.ld; en = x.en; mode = x.mode; sat = x.sat; load_val = x.lv;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: spec rules with plain integers; ping-pong is tracked as a
  // phase around a cycle of length 2*(M-1).
  function automatic bit model_tc(int M, in_t x, int c, bit d);
    if (!x.en || x.clr || x.ld) return 1'b0;
    case (x.mode)
      2'd0:    return c == M - 1;
      2'd1:    return c == 0;
      2'd2:    return (c == M - 1 && d) || (c == 0 && !d);
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_step(input int M, input int RV, input in_t x,
                                     inout int c, inout bit d, output bit w);
    int v, per, p, np;
    w = 1'b0;
    if (x.clr) begin
      c = RV; d = 1'b1;
    end else if (x.ld) begin
      v = (int'(x.lv) >= M) ? M - 1 : int'(x.lv);
      c = v;
      if (x.mode == 2'd2) begin
        if (v == 0) d = 1'b1;
        else if (v == M - 1) d = 1'b0;
      end
    end else if (x.en) begin
      case (x.mode)
        2'd0: begin
          d = 1'b1;
          if (c < M - 1) c = c + 1;
          else if (!x.sat) begin c = 0; w = 1'b1; end
        end
        2'd1: begin
          d = 1'b0;
          if (c > 0) c = c - 1;
          else if (!x.sat) begin c = M - 1; w = 1'b1; end
        end
        2'd2: begin
          per = 2 * (M - 1);
          p   = d ? c : (per - c) % per;
          np  = (p + 1) % per;
          c   = (np <= M - 1) ? np : per - np;
          if (c == 0) d = 1'b1;
          else if (c == M - 1) d = 1'b0;
          else d = (np < M);
        end
        default: ;
      endcase
    end
  endfunction

  initial begin
    vec_t tbl[$];
    int   pc[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    bit   pd[8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    int   mm[3] = '{10, 4, 16};
    int   rv[3] = '{9, 3, 15};
    int   mc[3];
    bit   md[3];
    bit   mw[3];
    int   pre, post;
    in_t  x;

    drive(I(0, 0, 0, 0, 0, 0));
    #1;

    // ---- Directed table against the MODULUS=10 instance ----
    tbl.push_back(mk(I(1, 0, 0, 0, 0, 0), 0, 9, 1, 0));
    for (int i = 0; i <= 10; i++) begin
      pre  = (i <= 9) ? 9 - i : 9;
      post = (pre == 0) ? 9 : pre - 1;
      tbl.push_back(mk(I(0, 0, 1, 1, 0, 0), pre == 0, post, 0, pre == 0));
    end
    tbl.push_back(mk(I(0, 1, 1, 0, 1, 0), 0, 0, 0, 0));
    for (int i = 0; i < 12; i++) begin
      pre  = (i < 9) ? i : 9;
      post = (i + 1 < 9) ? i + 1 : 9;
      tbl.push_back(mk(I(0, 0, 1, 0, 1, 0), pre == 9, post, 1, 0));
    end
    tbl.push_back(mk(I(0, 1, 1, 0, 0, 12), 0, 9, 1, 0));
    tbl.push_back(mk(I(0, 1, 0, 0, 0, 3), 0, 3, 1, 0));
    tbl.push_back(mk(I(1, 1, 1, 0, 0, 7), 0, 9, 1, 0));
    tbl.push_back(mk(I(0, 1, 1, 0, 0, 5), 0, 5, 1, 0));
    tbl.push_back(mk(I(0, 0, 1, 0, 0, 0), 0, 6, 1, 0));
    tbl.push_back(mk(I(1, 0, 1, 0, 0, 0), 0, 9, 1, 0));
    tbl.push_back(mk(I(0, 0, 1, 0, 0, 0), 1, 0, 1, 1));
    tbl.push_back(mk(I(1, 0, 1, 0, 0, 0), 0, 9, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(I(0, 0, 0, 0, 0, 0), 0, 9, 1, 0));
    tbl.push_back(mk(I(0, 0, 1, 3, 0, 0), 0, 9, 1, 0));
    tbl.push_back(mk(I(0, 0, 1, 3, 1, 0), 0, 9, 1, 0));
    tbl.push_back(mk(I(0, 1, 1, 1, 1, 0), 0, 0, 1, 0));
    tbl.push_back(mk(I(0, 0, 1, 1, 1, 0), 1, 0, 0, 0));
    tbl.push_back(mk(I(0, 0, 1, 1, 1, 0), 1, 0, 0, 0));
    tbl.push_back(mk(I(0, 1, 1, 2, 0, 9), 0, 9, 0, 0));
    tbl.push_back(mk(I(0, 1, 1, 2, 0, 0), 0, 0, 1, 0));
    tbl.push_back(mk(I(0, 1, 1, 2, 0, 4), 0, 4, 1, 0));
    tbl.push_back(mk(I(0, 0, 1, 2, 1, 0), 0, 5, 1, 0));

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      #1;
      chk($sformatf("tbl%0d.tc", k), int'(tc_w[0]), int'(tbl[k].tc));
      edge_step();
      chk($sformatf("tbl%0d.count", k), int'(cnt_w[0]), tbl[k].cnt);
      chk($sformatf("tbl%0d.dir", k), int'(dir_w[0]), int'(tbl[k].dir));
      chk($sformatf("tbl%0d.wrap", k), int'(wrap_w[0]), int'(tbl[k].wrap));
    end

    // ---- MODULUS=4 ping-pong bounce ----
    drive(I(0, 1, 1, 2, 0, 0)); edge_step();
    chk("pp.load.count", int'(cnt_w[1]), 0);
    chk("pp.load.dir", int'(dir_w[1]), 1);
    for (int i = 0; i < 8; i++) begin
      drive(I(0, 0, 1, 2, 0, 0)); edge_step();
      chk($sformatf("pp%0d.count", i), int'(cnt_w[1]), pc[i]);
      chk($sformatf("pp%0d.dir", i), int'(dir_w[1]), int'(pd[i]));
      chk($sformatf("pp%0d.wrap", i), int'(wrap_w[1]), 0);
    end

    // Ping-pong entered at the top while pointing up: reverse first, then step.
    drive(I(0, 1, 1, 0, 0, 3)); edge_step();
    drive(I(0, 0, 1, 0, 1, 0)); #1;
    chk("sat_up.tc", int'(tc_w[1]), 1);
    edge_step();
    chk("sat_up.count", int'(cnt_w[1]), 3);
    drive(I(0, 0, 1, 2, 0, 0)); #1;
    chk("pp_top.tc", int'(tc_w[1]), 1);
    edge_step();
    chk("pp_top.count", int'(cnt_w[1]), 2);
    chk("pp_top.dir", int'(dir_w[1]), 0);
    drive(I(0, 1, 1, 0, 0, 0)); edge_step();
    drive(I(0, 0, 1, 1, 1, 0)); edge_step();
    drive(I(0, 0, 1, 2, 0, 0)); #1;
    chk("pp_bot.tc", int'(tc_w[1]), 1);
    edge_step();
    chk("pp_bot.count", int'(cnt_w[1]), 1);
    chk("pp_bot.dir", int'(dir_w[1]), 1);
    drive(I(0, 1, 0, 2, 0, 12)); edge_step();
    chk("pp_clamp.count", int'(cnt_w[1]), 3);
    chk("pp_clamp.dir", int'(dir_w[1]), 0);

    // ---- Default parameters: legacy 15..0,15 down sequence ----
    drive(I(1, 0, 0, 0, 0, 0)); edge_step();
    chk("legacy.reset", int'(cnt_w[2]), 15);
    for (int i = 0; i <= 16; i++) begin
      pre  = (i <= 15) ? 15 - i : 15;
      post = (pre == 0) ? 15 : pre - 1;
      drive(I(0, 0, 1, 1, 0, 0)); edge_step();
      chk($sformatf("legacy%0d.count", i), int'(cnt_w[2]), post);
      chk($sformatf("legacy%0d.wrap", i), int'(wrap_w[2]), int'(pre == 0));
    end

    // ---- Random stimulus against the model, all three instances ----
    drive(I(1, 0, 0, 0, 0, 0)); edge_step();
    for (int k = 0; k < 3; k++) begin
      mc[k] = rv[k]; md[k] = 1'b1; mw[k] = 1'b0;
    end
    for (int n = 0; n < 1500; n++) begin
      x = I($urandom_range(39) == 0, $urandom_range(7) == 0, $urandom_range(4) != 0,
            2'($urandom_range(3)), 1'($urandom_range(1)), $urandom_range(15));
      drive(x);
      #1;
      for (int k = 0; k < 3; k++)
        chk($sformatf("rnd%0d.m%0d.tc", n, mm[k]), int'(tc_w[k]),
            int'(model_tc(mm[k], x, mc[k], md[k])));
      edge_step();
      for (int k = 0; k < 3; k++) begin
        model_step(mm[k], rv[k], x, mc[k], md[k], mw[k]);
        chk($sformatf("rnd%0d.m%0d.count", n, mm[k]), int'(cnt_w[k]), mc[k]);
        chk($sformatf("rnd%0d.m%0d.dir", n, mm[k]), int'(dir_w[k]), int'(md[k]));
        chk($sformatf("rnd%0d.m%0d.wrap", n, mm[k]), int'(wrap_w[k]), int'(mw[k]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
